fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS32 pipeline; sits directly upstream of imem.
- Owns the program counter and drives the imem byte address (imem_a).
- Captures the returned instruction word into the IF/ID register with its PC and PC+4 for decode.
- Handles stall, branch/jump redirect, and halt/resume through a small control FSM.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word placed in id_instr when the slot is squashed or empty (sll $0,$0,0).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit hold; freezes PC and IF/ID.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  new PC when redirect_valid=1.
- halt_req  in  1  request fetch stop.
- resume  in  1  leave HALT.
- imem_a  out  32  fetch address to imem; always equals the internal pc register (combinational).
- imem_rd  in  32  instruction word from imem; combinational, valid in the same cycle.
- id_instr  out  32  registered instruction to decode.
- id_pc  out  32  registered PC of id_instr.
- id_pc_plus4  out  32  registered id_pc+4.
- id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (sampled on clk edge while reset=1): pc=RESET_PC, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, id_valid=0, state=BOOT, halted=0. Reset overrides every other input, including mid-redirect or in HALT.
- FSM states:
  - BOOT: one cycle with no capture; id_valid stays 0; pc unchanged; next state RUN. This gives imem one full cycle on RESET_PC.
  - RUN: normal fetch.
  - HALT: pc frozen; IF/ID loaded with NOP, id_valid=0; halted=1. resume=1 returns to RUN next edge; fetch restarts at the frozen pc.
- RUN edge priority, highest first:
  1. redirect_valid: pc<=redirect_target; IF/ID<=NOP, id_valid<=0, which squashes the wrong-path fetch. Redirect wins over stall and halt_req; halt_req is re-evaluated the next cycle.
  2. stall: pc and all IF/ID outputs hold their values.
  3. halt_req: current fetch is discarded (IF/ID<=NOP, id_valid<=0); pc holds; state<=HALT.
  4. Normal: id_instr<=imem_rd, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
- Fetch-to-decode latency is 1 cycle. Sustained throughput is 1 instruction per cycle with no stall or redirect.
- Arithmetic: pc+4 is a 32-bit modulo add, so 32'hFFFF_FFFC wraps to 0 with no flag. redirect_target is used as given; low two bits are not masked unless the optional feature is on.
- redirect_valid or stall during BOOT or HALT: redirect updates pc only (state unchanged); stall is ignored.
- resume while not in HALT is ignored. resume and halt_req together in HALT: resume wins.
- imem_a changes only after a clk edge and is glitch-free relative to the pc register.

Optional Feature:
- FETCH_ALIGN_CHECK_EN, when defined:
  - Adds output misalign (1 bit, reset 0).
  - A redirect whose target has [1:0]!=0 forces pc<=target&~3 and sets sticky misalign=1 until reset.
  - The fetch at the aligned address then proceeds normally.
- When not defined: no misalign port; target bits [1:0] pass straight into pc.

Decomposition:
- Shared package (mips_pkg): fetch FSM state encoding (BOOT, RUN, HALT), NOP_INSTR constant, RESET_PC default, 32-bit word width constant.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with hold (stall) and squash (load NOP, clear valid) controls. The FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset, then release; imem returns 32'h2008_0005 at addr 0 and 32'h2009_000C at addr 4 -> BOOT cycle has id_valid=0; next edge id_instr=2008_0005, id_pc=0, id_pc_plus4=4; following edge id_pc=4.
- stall=1 for 3 cycles at pc=8 -> imem_a stays 8 and IF/ID unchanged for 3 cycles; resumes at 8 afterwards.
- redirect_valid=1, target=32'h40 with stall=1 in the same cycle -> next edge pc=40, id_valid=0; the edge after that gives id_pc=40.
- halt_req at pc=C -> halted=1, id_valid=0, imem_a=C held; resume -> next edge RUN, then id_pc=C.
- pc forced to FFFF_FFFC via redirect -> after that fetch, imem_a=0 and id_pc_plus4=0 (wrap).
- With FETCH_ALIGN_CHECK_EN: redirect to 32'h22 -> pc=20, misalign=1 and sticky until reset; reset clears it.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: word width, fetch FSM encoding and reset defaults.
package mips_pkg;

  localparam int          WORD_W        = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: squash loads NOP and clears valid, load captures, otherwise holds.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              squash,
  input  logic              load,
  input  logic [WORD_W-1:0] instr_p0,
  input  logic [WORD_W-1:0] pc_p0,
  input  logic [WORD_W-1:0] pc_plus4_p0,
  output logic [WORD_W-1:0] id_instr,
  output logic [WORD_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_pc_plus4,
  output logic              id_valid
);

  // IF -> ID boundary; squash leaves the PC fields alone since id_valid=0 marks them stale
  always_ff @(posedge clk) begin
    if (reset) begin
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (squash) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr    <= instr_p0;
      id_pc       <= pc_p0;
      id_pc_plus4 <= pc_plus4_p0;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: PC, BOOT/RUN/HALT control FSM and IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN adds word-alignment of redirects and a sticky misalign flag.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [WORD_W-1:0] imem_a,
  input  logic [WORD_W-1:0] imem_rd,
  output logic [WORD_W-1:0] id_instr,
  output logic [WORD_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_pc_plus4,
  output logic              id_valid,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              misalign,
`endif
  output logic              halted
);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] target_eff;
  logic              squash;
  logic              load;

  assign imem_a   = pc;
  assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_eff = {redirect_target[WORD_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset)
      misalign <= 1'b0;
    else if (redirect_valid && (redirect_target[1:0] != 2'b00))
      misalign <= 1'b1;
  end
`else
  assign target_eff = redirect_target;
`endif

  always_comb begin
    squash = 1'b0;
    load   = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect_valid)
          squash = 1'b1;
        else if (!stall) begin
          if (halt_req) squash = 1'b1;
          else          load   = 1'b1;
        end
      end
      ST_HALT: squash = 1'b1;
      default: ;
    endcase
  end

  // PC and control FSM; redirect outranks stall, which outranks halt_req
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      state  <= ST_BOOT;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (redirect_valid) pc <= target_eff;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid)
            pc <= target_eff;
          else if (!stall) begin
            if (halt_req) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        ST_HALT: begin
          if (redirect_valid) pc <= target_eff;
          if (resume) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_BOOT;
          halted <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .squash     (squash),
    .load       (load),
    .instr_p0   (imem_rd),
    .pc_p0      (pc),
    .pc_plus4_p0(pc_plus4),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_valid   (id_valid)
  );

endmodule
